// File: rtl/wisc_pkg.sv
// Shared ISA constants for the pipeline: opcode encoding, flag bit positions
// and the per-opcode flag write mask.
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LLB    = 4'b1010,
    OP_LHB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_e;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_W = 3;

  // Which flags an opcode is allowed to write; all others hold.
  function automatic logic [FLAG_W-1:0] flag_mask(input logic [3:0] op);
    logic [FLAG_W-1:0] m;
    m = '0;
    case (opcode_e'(op))
      OP_ADD, OP_SUB: m = '1;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ex_mem_flag_stage_flag_reg.sv
// Z/V/N flag storage with per-opcode write masking.
// Build option EX_FLAG_FWD_EN: when defined, the flag outputs bypass the
// register during an update cycle and show the post-update value; otherwise
// the outputs are the registered flags only. Stored state is the same either way.
import wisc_pkg::*;

module flag_reg #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              upd_i,
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              ovfl_i,
  output logic [FLAG_W-1:0] flags_o
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] new_val;
  logic [FLAG_W-1:0] mask;

  // Merge freshly computed flags into the held ones under the opcode mask
  always_comb begin
    new_val         = '0;
    new_val[FLAG_Z] = (result_i == '0);
    new_val[FLAG_V] = ovfl_i;
    new_val[FLAG_N] = result_i[DATA_W-1];
    mask            = upd_i ? flag_mask(opcode_i) : '0;
    flags_d         = (flags_q & ~mask) | (new_val & mask);
  end

  // Flag state register
  always_ff @(posedge clk_i) begin
    if (rst_i) flags_q <= '0;
    else       flags_q <= flags_d;
  end

`ifdef EX_FLAG_FWD_EN
  // flags_d equals flags_q outside an update cycle, so it is the bypassed view
  assign flags_o = flags_d;
`else
  assign flags_o = flags_q;
`endif

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with flush/stall control, plus the branch flags.
// Flag forwarding is selected by the EX_FLAG_FWD_EN macro inside flag_reg.
import wisc_pkg::*;

module ex_mem_flag_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovfl,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              mem_halt,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
);

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] alu_q,    alu_d;
  logic [REG_W-1:0]  rd_q,     rd_d;
  logic              rw_q,     rw_d;
  logic              mr_q,     mr_d;
  logic              mw_q,     mw_d;
  logic [DATA_W-1:0] sd_q,     sd_d;
  logic              halt_q,   halt_d;
  logic              flag_upd;
  logic [FLAG_W-1:0] flags;

  // Next-state: flush loads a bubble (data held), stall holds, else capture
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    sd_d    = sd_q;
    halt_d  = halt_q;
    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      halt_d  = 1'b0;
    end else if (!stall) begin
      valid_d = ex_valid;
      alu_d   = alu_out;
      rd_d    = ex_rd;
      rw_d    = ex_valid & ex_regwrite;
      mr_d    = ex_valid & ex_memread;
      mw_d    = ex_valid & ex_memwrite;
      sd_d    = ex_store_data;
      halt_d  = ex_valid & (ex_opcode == OP_HLT);
    end
  end

  // EX/MEM register bank; reset overrides flush and stall
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      sd_q    <= '0;
      halt_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      sd_q    <= sd_d;
      halt_q  <= halt_d;
    end
  end

  assign flag_upd = ex_valid & ~flush & ~stall;

  flag_reg #(.DATA_W(DATA_W)) u_flag_reg (
    .clk_i    (clk),
    .rst_i    (rst),
    .upd_i    (flag_upd),
    .opcode_i (ex_opcode),
    .result_i (alu_out),
    .ovfl_i   (alu_ovfl),
    .flags_o  (flags)
  );

  assign mem_valid      = valid_q;
  assign mem_alu_out    = alu_q;
  assign mem_rd         = rd_q;
  assign mem_regwrite   = rw_q;
  assign mem_memread    = mr_q;
  assign mem_memwrite   = mw_q;
  assign mem_store_data = sd_q;
  assign mem_halt       = halt_q;
  assign flag_z         = flags[FLAG_Z];
  assign flag_v         = flags[FLAG_V];
  assign flag_n         = flags[FLAG_N];

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Bench for ex_mem_flag_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_ex_mem_flag_stage;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 4;

`ifdef EX_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, stall, flush, ex_valid, alu_ovfl;
  logic [3:0]        ex_opcode;
  logic [DATA_W-1:0] alu_out, ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_regwrite, ex_memread, ex_memwrite;
  logic              mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_halt;
  logic [DATA_W-1:0] mem_alu_out, mem_store_data;
  logic [REG_W-1:0]  mem_rd;
  logic              flag_z, flag_v, flag_n;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit                m_known = 1'b0;
  logic              m_valid, m_rw, m_mr, m_mw, m_halt;
  logic [DATA_W-1:0] m_alu, m_sd;
  logic [REG_W-1:0]  m_rd;
  logic              f_z, f_v, f_n;

  ex_mem_flag_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .alu_out(alu_out),
    .alu_ovfl(alu_ovfl), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_store_data(mem_store_data),
    .mem_halt(mem_halt), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Flags after this instruction, from the ISA rules.
  function automatic logic [2:0] next_flags(input logic [2:0] cur_zvn);
    logic [2:0] r;
    r = cur_zvn;
    if (ex_valid && !flush && !stall) begin
      if (ex_opcode == 4'd0 || ex_opcode == 4'd1)
        r = {alu_out == 16'h0, alu_ovfl, alu_out[DATA_W-1]};
      else if (ex_opcode == 4'd2 || ex_opcode == 4'd4 ||
               ex_opcode == 4'd5 || ex_opcode == 4'd6)
        r[2] = (alu_out == 16'h0);
    end
    return r;
  endfunction

  task automatic compare();
    logic [2:0] ef;
    if (!m_known) return;
    ef = FWD ? next_flags({f_z, f_v, f_n}) : {f_z, f_v, f_n};
    check("mem_valid",      mem_valid,      m_valid);
    check("mem_alu_out",    mem_alu_out,    m_alu);
    check("mem_rd",         mem_rd,         m_rd);
    check("mem_regwrite",   mem_regwrite,   m_rw);
    check("mem_memread",    mem_memread,    m_mr);
    check("mem_memwrite",   mem_memwrite,   m_mw);
    check("mem_store_data", mem_store_data, m_sd);
    check("mem_halt",       mem_halt,       m_halt);
    check("flags_zvn",      {flag_z, flag_v, flag_n}, ef);
  endtask

  task automatic model_edge();
    logic [2:0] nf;
    nf = next_flags({f_z, f_v, f_n});
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw, m_halt} = '0;
      m_alu = '0; m_sd = '0; m_rd = '0;
      {f_z, f_v, f_n} = 3'b000;
      m_known = 1'b1;
    end else begin
      {f_z, f_v, f_n} = nf;
      if (flush) begin
        {m_valid, m_rw, m_mr, m_mw, m_halt} = '0;
      end else if (!stall) begin
        m_valid = ex_valid;
        m_alu   = alu_out;
        m_rd    = ex_rd;
        m_sd    = ex_store_data;
        m_rw    = ex_valid && ex_regwrite;
        m_mr    = ex_valid && ex_memread;
        m_mw    = ex_valid && ex_memwrite;
        m_halt  = ex_valid && ex_opcode == 4'hF;
      end
    end
  endtask

  // Called just after a falling edge with inputs set; ends at the next falling edge.
  task automatic cycle();
    #2;
    compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; ex_valid = 0;
    ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; alu_ovfl = 0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [15:0] res, input logic ov);
    idle();
    ex_valid = 1; ex_opcode = op; alu_out = res; alu_ovfl = ov;
    ex_rd = 4'd3; ex_regwrite = 1; ex_store_data = 16'hA5A5;
  endtask

  initial begin
    idle();
    ex_opcode = 4'hF; alu_out = 16'hBEEF; ex_rd = 4'hF; ex_store_data = 16'h1234;
    @(negedge clk);

    // Reset with stall and flush both asserted
    rst = 1; stall = 1; flush = 1; ex_valid = 1;
    ex_regwrite = 1; ex_memread = 1; ex_memwrite = 1; alu_ovfl = 1;
    cycle();
    idle(); #1;
    check("reset_all", {mem_valid, mem_alu_out, mem_rd, mem_regwrite, mem_memread,
                        mem_memwrite, mem_store_data, mem_halt, flag_z, flag_v, flag_n}, '0);

    // ADD then XOR flag updates
    instr(4'h0, 16'h7FFF, 1'b1); cycle();
    idle(); #1; check("add_zvn", {flag_z, flag_v, flag_n}, 3'b010);
    check("add_alu", mem_alu_out, 16'h7FFF);
    instr(4'h2, 16'h0000, 1'b0); cycle();
    idle(); #1; check("xor_zvn", {flag_z, flag_v, flag_n}, 3'b110);

    // Build Z=N=V=1, then PADDSB must not touch flags
    instr(4'h1, 16'h8000, 1'b1); cycle();
    instr(4'h2, 16'h0000, 1'b0); cycle();
    idle(); #1; check("zvn_all_set", {flag_z, flag_v, flag_n}, 3'b111);
    instr(4'h7, 16'h0000, 1'b0); cycle();
    idle(); #1; check("paddsb_zvn", {flag_z, flag_v, flag_n}, 3'b111);
    check("paddsb_alu", mem_alu_out, 16'h0000);

    // Stall holds everything, stall+flush gives a bubble without flag change
    instr(4'h1, 16'h1234, 1'b0); ex_rd = 4'd5; stall = 1; cycle();
    idle(); #1; check("stall_hold", {mem_valid, mem_alu_out, mem_rd, flag_z, flag_v, flag_n},
                      {1'b1, 16'h0000, 4'd3, 3'b111});
    instr(4'h1, 16'h1234, 1'b0); stall = 1; flush = 1; cycle();
    idle(); #1; check("flush_bubble", {mem_valid, mem_regwrite, mem_alu_out, flag_z, flag_v, flag_n},
                      {1'b0, 1'b0, 16'h0000, 3'b111});

    // Halt is one-shot, invalid SW has no side effect
    instr(4'hF, 16'h0000, 1'b0); ex_regwrite = 0; cycle();
    idle(); #1; check("halt_set", mem_halt, 1'b1);
    cycle();
    #1; check("halt_not_sticky", mem_halt, 1'b0);
    instr(4'h9, 16'h0010, 1'b0); ex_valid = 0; ex_memwrite = 1; cycle();
    idle(); #1; check("invalid_sw", {mem_valid, mem_memwrite}, 2'b00);

    // Forwarding visibility of N
    instr(4'h0, 16'h0001, 1'b0); cycle();
    instr(4'h0, 16'h8000, 1'b0); #1;
    check("fwd_n_same_cycle", flag_n, FWD ? 1'b1 : 1'b0);
    cycle();
    idle(); #1; check("n_next_cycle", flag_n, 1'b1);

    // Reset during a stall discards the held instruction
    instr(4'h8, 16'h4444, 1'b0); ex_memread = 1; cycle();
    instr(4'h8, 16'h5555, 1'b0); stall = 1; cycle();
    rst = 1; stall = 1; cycle();
    idle(); #1; check("reset_mid_stall", {mem_valid, mem_memread, mem_alu_out, flag_n}, '0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) < 2);
      flush         = ($urandom_range(0, 99) < 10);
      stall         = ($urandom_range(0, 99) < 20);
      ex_valid      = ($urandom_range(0, 99) < 80);
      ex_opcode     = 4'($urandom_range(0, 15));
      alu_out       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      alu_ovfl      = 1'($urandom);
      ex_rd         = 4'($urandom);
      ex_regwrite   = 1'($urandom);
      ex_memread    = 1'($urandom);
      ex_memwrite   = 1'($urandom);
      ex_store_data = 16'($urandom);
      cycle();
    end
    idle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_flag_stage.md
EX_MEM_FLAG_STAGE -- requirements
Module: ex_mem_flag_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width of ALU result and store data.
REQ-002 SHALL have parameter REG_W, default 4, register-specifier width.
REQ-003 SHALL have one clock and synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have these control inputs: stall  input  1  hold EX/MEM contents; flush  input  1  squash the EX instruction.
REQ-005 SHALL have these EX-side inputs:
- ex_valid  input  1  EX holds a real instruction.
- ex_opcode  input  4  opcode.
- alu_out  input  DATA_W  ALU result, already saturated for ADD/SUB/PADDSB.
- alu_ovfl  input  1  signed overflow of ADD/SUB.
- ex_rd  input  REG_W  destination register.
- ex_regwrite, ex_memread, ex_memwrite  input  1 each  control bits.
- ex_store_data  input  DATA_W  SW data.
REQ-006 SHALL have these MEM-side outputs: mem_valid 1, mem_alu_out DATA_W, mem_rd REG_W, mem_regwrite 1, mem_memread 1, mem_memwrite 1, mem_store_data DATA_W, mem_halt 1 (HLT reached MEM).
REQ-007 SHALL have these flag outputs: flag_z, flag_v, flag_n, 1 bit each, to branch logic.

Function
REQ-008 SHALL use opcodes ADD=0000, SUB=0001, XOR=0010, RED=0011, SLL=0100, SRA=0101, ROR=0110, PADDSB=0111, LW=1000, SW=1001, LLB=1010, LHB=1011, B=1100, BR=1101, PCS=1110, HLT=1111.
REQ-009 SHALL apply control priority rst > flush > stall > normal advance on each rising edge.
REQ-010 On advance, SHALL capture all EX inputs into the MEM registers with one-cycle latency; mem_valid = ex_valid.
REQ-011 On flush, SHALL load a bubble: mem_valid, mem_regwrite, mem_memread, mem_memwrite and mem_halt = 0; data fields don't-care but SHALL be held.
REQ-012 On stall without flush, SHALL hold every MEM register and every flag unchanged.
REQ-013 SHALL gate mem_regwrite, mem_memread, mem_memwrite and mem_halt with ex_valid, so an invalid EX never produces side effects.
REQ-014 SHALL set mem_halt = 1 on advance when ex_valid and ex_opcode = HLT; mem_halt is not sticky.
REQ-015 SHALL update flags only when ex_valid, !flush and !stall: the flag-update event.
REQ-016 ADD/SUB SHALL update all flags: Z = (alu_out == 0), N = alu_out[DATA_W-1], V = alu_ovfl.
REQ-017 XOR, SLL, SRA and ROR SHALL update Z only; N and V hold.
REQ-018 All other opcodes, including PADDSB and RED, SHALL leave all flags unchanged.
REQ-019 Back-to-back flag-writing instructions SHALL each update in their own cycle, with no merge or loss.

Reset
REQ-020 While rst is asserted at a clock edge, all MEM registers and all flags SHALL become 0, regardless of stall or flush.
REQ-021 Reset mid-stall SHALL discard the held instruction; the first post-reset edge behaves per REQ-009.

Configuration
REQ-022 Macro EX_FLAG_FWD_EN, when defined, SHALL make flag_z/v/n combinationally show the post-update value during a flag-update event cycle, and the registered value otherwise.
REQ-023 Without EX_FLAG_FWD_EN, flag outputs SHALL be registered only, visible one cycle after the update event.
REQ-024 Registered flag state SHALL be identical in both builds.

Structure
REQ-025 Opcode constants and flag-index constants (Z=2, V=1, N=0) SHALL live in shared package wisc_pkg.
REQ-026 Flag storage and update-mask logic SHALL be a sub-module flag_reg; the pipeline register SHALL stay in the top module.

Verification
REQ-027 Reset test: drive rst=1 with stall=1 and flush=1 -> all outputs 0 next cycle.
REQ-028 Flag update test:
- ADD, alu_out=0x7FFF, alu_ovfl=1 -> Z=0, N=0, V=1.
- Then XOR, alu_out=0x0000 -> Z=1, N=0, V=1.
REQ-029 No-update test: flags Z=1, N=1, V=1, then PADDSB alu_out=0x0000 -> flags unchanged; mem_alu_out=0x0000 next cycle.
REQ-030 Stall/flush test:
- SUB in EX with stall=1 -> MEM regs and flags hold.
- Same cycle with flush=1 as well -> mem_valid=0 and flags unchanged.
REQ-031 Halt/invalid test:
- ex_valid=1, HLT -> mem_halt=1 one cycle later.
- ex_valid=0, SW -> mem_memwrite=0.
REQ-032 Forwarding test: ADD alu_out=0x8000 -> flag_n=1 same cycle with EX_FLAG_FWD_EN, next cycle without.
